tmds_serializer: RTL and testbench

TMDS_SERIALIZER -- requirements
Module: tmds_serializer

---
 rtl/dvi_pkg.sv | 27 ++
 rtl/tmds_word_fifo.sv | 61 ++++++
 rtl/tmds_serializer.sv | 116 +++++++++++
 tb/tb_tmds_serializer.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dvi_pkg.sv
// Shared DVI/TMDS constants: symbol width, control symbols and the
// clock-channel word generator used by the serializer.
package dvi_pkg;

    localparam int TMDS_WORD_W = 10;

    typedef logic [TMDS_WORD_W-1:0] tmds_word_t;

    // Control symbols sent during blanking, indexed by {C1,C0}.
    localparam tmds_word_t CTRL_00 = 10'b1101010100;
    localparam tmds_word_t CTRL_01 = 10'b0010101011;
    localparam tmds_word_t CTRL_10 = 10'b0101010100;
    localparam tmds_word_t CTRL_11 = 10'b1010101011;

    // Clock-channel word: lower half ones, upper half zeros, so the
    // serial clock is high for the first half of every symbol period.
    function automatic logic [31:0] tmds_clk_word(input int width);
        logic [31:0] w_word;
        if (width / 2 >= 32) begin
            w_word = '1;
        end else begin
            w_word = (32'h1 << (width / 2)) - 32'h1;
        end
        return w_word;
    endfunction

endpackage

// File: rtl/tmds_word_fifo.sv
// Two-entry symbol FIFO feeding the TMDS shift registers.
// Ports: i_clk/i_rst (sync, active-high), i_push/o_ready/i_data push side,
//        i_pop/o_valid/o_data pop side (o_data is the current head).
module tmds_word_fifo #(
    parameter int DATA_W = 30
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;

    logic w_push;
    logic w_pop;

    // Ready/valid depend on registered occupancy only: a pop in the
    // same cycle never opens room for a push, and a word pushed into
    // an empty FIFO is not visible as head until the next cycle.
    assign o_ready = ~i_rst & (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rptr];

    assign w_push = i_push & o_ready;
    assign w_pop  = i_pop & o_valid;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tmds_serializer.sv
// TMDS serializer: buffers symbol sets in a 2-entry FIFO and shifts them
// out LSB-first, LANE_W bits per channel per clock, plus a clock channel.
// Ports: clk_tmds, rst (sync, active-high); in_valid/in_ready/in_data
//        symbol input; fill_data sent on underrun; ser_data/ser_clk serial
//        outputs; word_strobe marks symbol start; underrun sticky flag
//        cleared by underrun_clr.
module tmds_serializer
    import dvi_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int WORD_W = TMDS_WORD_W,
    parameter int LANE_W = 1
) (
    input  logic                     clk_tmds,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_CH*WORD_W-1:0] in_data,
    input  logic [NUM_CH*WORD_W-1:0] fill_data,
    output logic [NUM_CH*LANE_W-1:0] ser_data,
    output logic [LANE_W-1:0]        ser_clk,
    output logic                     word_strobe,
    output logic                     underrun,
    input  logic                     underrun_clr
);

    localparam int BEATS  = WORD_W / LANE_W;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SYM_W  = NUM_CH * WORD_W;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [WORD_W-1:0] CLK_WORD  = WORD_W'(tmds_clk_word(WORD_W));

    logic [BEAT_W-1:0]             r_beat;
    logic [NUM_CH-1:0][WORD_W-1:0] r_shift;
    logic [WORD_W-1:0]             r_clk_sh;
    logic                          r_strobe;
    logic                          r_underrun;

    logic             w_load;
    logic             w_pop;
    logic             w_head_valid;
    logic [SYM_W-1:0] w_head;

    // The last beat of a symbol period ends with a load of the next symbol.
    assign w_load = (r_beat == LAST_BEAT);
    assign w_pop  = w_load & w_head_valid;

    tmds_word_fifo #(
        .DATA_W (SYM_W)
    ) u_fifo (
        .i_clk   (clk_tmds),
        .i_rst   (rst),
        .i_push  (in_valid),
        .o_ready (in_ready),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_valid (w_head_valid),
        .o_data  (w_head)
    );

    always_ff @(posedge clk_tmds) begin
        if (rst) begin
            r_beat <= '0;
        end else if (w_load) begin
            r_beat <= '0;
        end else begin
            r_beat <= r_beat + BEAT_W'(1);
        end
    end

    // Shift registers double as output registers; an empty FIFO at load
    // time substitutes the fill symbol set.
    always_ff @(posedge clk_tmds) begin
        if (rst) begin
            r_shift  <= '0;
            r_clk_sh <= '0;
        end else if (w_load) begin
            r_shift  <= w_head_valid ? w_head : fill_data;
            r_clk_sh <= CLK_WORD;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                r_shift[k] <= r_shift[k] >> LANE_W;
            end
            r_clk_sh <= r_clk_sh >> LANE_W;
        end
    end

    always_ff @(posedge clk_tmds) begin
        if (rst) begin
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= w_load;
        end
    end

    // A fill load takes priority over a simultaneous clear.
    always_ff @(posedge clk_tmds) begin
        if (rst) begin
            r_underrun <= 1'b0;
        end else if (w_load && !w_head_valid) begin
            r_underrun <= 1'b1;
        end else if (underrun_clr) begin
            r_underrun <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        assign ser_data[k*LANE_W +: LANE_W] = r_shift[k][LANE_W-1:0];
    end

    assign ser_clk     = r_clk_sh[LANE_W-1:0];
    assign word_strobe = r_strobe;
    assign underrun    = r_underrun;

endmodule

// File: tb/tb_tmds_serializer.sv
// Scoreboard bench for tmds_serializer: SDR 3-channel and DDR 1-channel.
// Monitors rebuild whole symbols from the serial lanes and compare.
module tb_tmds_serializer;

    localparam logic [9:0]  C00  = 10'b1101010100;
    localparam logic [29:0] FILL = {C00, C00, C00};
    localparam logic [9:0]  CLKW = 10'b0000011111;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [29:0] in_data = '0;
    logic [29:0] fill_data = FILL;
    logic [2:0]  ser_data;
    logic        ser_clk;
    logic        word_strobe;
    logic        underrun;
    logic        underrun_clr = 1'b0;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [9:0]  in_data2 = '0;
    logic [9:0]  fill_data2 = C00;
    logic [1:0]  ser_data2;
    logic [1:0]  ser_clk2;
    logic        word_strobe2;
    logic        underrun2;
    logic        underrun_clr2 = 1'b0;

    tmds_serializer #(.NUM_CH(3), .WORD_W(10), .LANE_W(1)) u_dut (
        .clk_tmds     (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .fill_data    (fill_data),
        .ser_data     (ser_data),
        .ser_clk      (ser_clk),
        .word_strobe  (word_strobe),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    tmds_serializer #(.NUM_CH(1), .WORD_W(10), .LANE_W(2)) u_dut2 (
        .clk_tmds     (clk),
        .rst          (rst),
        .in_valid     (in_valid2),
        .in_ready     (in_ready2),
        .in_data      (in_data2),
        .fill_data    (fill_data2),
        .ser_data     (ser_data2),
        .ser_clk      (ser_clk2),
        .word_strobe  (word_strobe2),
        .underrun     (underrun2),
        .underrun_clr (underrun_clr2)
    );

    int checks = 0;
    int errors = 0;

    logic [29:0] q1 [$];
    logic [9:0]  q2 [$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    // Leaves the bench in cycle 0 after reset release.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        in_valid2 = 1'b0;
        underrun_clr = 1'b0;
        q1.delete();
        q2.delete();
        tick(2);
        rst = 1'b0;
    endtask

    task automatic wait_drain(input bit second);
        for (int i = 0; i < 300; i++) begin
            if ((second ? q2.size() : q1.size()) == 0) break;
            tick(1);
        end
        if ((second ? q2.size() : q1.size()) != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d words never emitted",
                     second ? q2.size() : q1.size());
            q1.delete();
            q2.delete();
        end
    endtask

    // Monitor for the SDR instance.
    bit          m1_act;
    bit          m1_seen;
    int          m1_cnt;
    int          m1_since;
    logic [29:0] m1_word;
    logic [9:0]  m1_cw;
    logic [29:0] m1_exp;

    always @(negedge clk) begin
        if (rst) begin
            m1_act = 1'b0;
            m1_seen = 1'b0;
            m1_since = 0;
        end else begin
            if (word_strobe) begin
                if (m1_seen) chk("strobe_period", 64'(m1_since), 64'd10);
                m1_seen = 1'b1;
                m1_since = 0;
                m1_act = 1'b1;
                m1_cnt = 0;
                m1_word = '0;
                m1_cw = '0;
            end
            if (m1_act) begin
                for (int k = 0; k < 3; k++) begin
                    m1_word |= 30'((ser_data >> k) & 3'b001) << (k*10 + m1_cnt);
                end
                m1_cw |= 10'(ser_clk) << m1_cnt;
                m1_cnt++;
                if (m1_cnt == 10) begin
                    m1_act = 1'b0;
                    if (q1.size() > 0) begin
                        m1_exp = q1.pop_front();
                        chk("word", 64'(m1_word), 64'(m1_exp));
                        chk("clk_word", 64'(m1_cw), 64'(CLKW));
                    end
                end
            end
            m1_since++;
        end
    end

    // Monitor for the DDR instance.
    bit         m2_act;
    bit         m2_seen;
    int         m2_cnt;
    int         m2_since;
    logic [9:0] m2_word;
    logic [9:0] m2_cw;
    logic [9:0] m2_exp;

    always @(negedge clk) begin
        if (rst) begin
            m2_act = 1'b0;
            m2_seen = 1'b0;
            m2_since = 0;
        end else begin
            if (word_strobe2) begin
                if (m2_seen) chk("strobe_period2", 64'(m2_since), 64'd5);
                m2_seen = 1'b1;
                m2_since = 0;
                m2_act = 1'b1;
                m2_cnt = 0;
                m2_word = '0;
                m2_cw = '0;
            end
            if (m2_act) begin
                m2_word |= 10'(ser_data2) << (2*m2_cnt);
                m2_cw |= 10'(ser_clk2) << (2*m2_cnt);
                m2_cnt++;
                if (m2_cnt == 5) begin
                    m2_act = 1'b0;
                    if (q2.size() > 0) begin
                        m2_exp = q2.pop_front();
                        chk("word2", 64'(m2_word), 64'(m2_exp));
                        chk("clk_word2", 64'(m2_cw), 64'(CLKW));
                    end
                end
            end
            m2_since++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        bit          rdy;
        logic [29:0] a_w;
        logic [29:0] b_w;

        // Reset state.
        tick(2);
        at_neg();
        chk("rst_ser_data", 64'(ser_data), 64'd0);
        chk("rst_ser_clk", 64'(ser_clk), 64'd0);
        chk("rst_strobe", 64'(word_strobe), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        at_neg();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Constant patterns on three channels.
        do_reset();
        in_data = {10'h3FF, 10'h000, 10'h155};
        in_valid = 1'b1;
        repeat (3) q1.push_back(in_data);
        tick(9);
        at_neg();
        chk("t1_no_strobe_b9", 64'(word_strobe), 64'd0);
        tick(1);
        at_neg();
        chk("t1_strobe", 64'(word_strobe), 64'd1);
        chk("t1_first_bits", 64'(ser_data), 64'b101);
        wait_drain(1'b0);
        in_valid = 1'b0;
        chk("t1_no_underrun", 64'(underrun), 64'd0);

        // Underrun with control-symbol fill, clear and set-wins.
        do_reset();
        repeat (3) q1.push_back(FILL);
        tick(8);
        at_neg();
        chk("t2_underrun_pre", 64'(underrun), 64'd0);
        tick(2);
        at_neg();
        chk("t2_underrun_set", 64'(underrun), 64'd1);
        chk("t2_fill_bit0", 64'(ser_data), 64'd0);
        tick(2);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        at_neg();
        chk("t2_cleared", 64'(underrun), 64'd0);
        tick(7);
        at_neg();
        chk("t2_reset_again", 64'(underrun), 64'd1);
        tick(2);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        at_neg();
        chk("t2_cleared2", 64'(underrun), 64'd0);
        tick(6);
        underrun_clr = 1'b1;
        tick(1);
        underrun_clr = 1'b0;
        at_neg();
        chk("t2_set_wins", 64'(underrun), 64'd1);
        wait_drain(1'b0);

        // Two bits per clock.
        do_reset();
        in_data2 = 10'b1001110010;
        in_valid2 = 1'b1;
        repeat (2) q2.push_back(in_data2);
        tick(4);
        at_neg();
        chk("t3_no_strobe", 64'(word_strobe2), 64'd0);
        tick(1);
        at_neg();
        chk("t3_strobe", 64'(word_strobe2), 64'd1);
        chk("t3_pair0", 64'(ser_data2), 64'b10);
        tick(1);
        at_neg();
        chk("t3_pair1", 64'(ser_data2), 64'b00);
        wait_drain(1'b1);
        in_valid2 = 1'b0;

        // Back-pressure with incrementing data.
        do_reset();
        for (int n = 0; n < 6; n++) q1.push_back(30'(n));
        acc = 0;
        in_data = '0;
        in_valid = 1'b1;
        for (int c = 0; c < 42; c++) begin
            at_neg();
            rdy = in_ready;
            if (c == 2) begin
                chk("t4_ready_low", 64'(in_ready), 64'd0);
                chk("t4_two_accepts", 64'(acc), 64'd2);
            end
            @(posedge clk);
            #1;
            if (rdy) acc++;
            in_data = 30'(acc);
        end
        in_valid = 1'b0;
        chk("t4_accept_count", 64'(acc), 64'd6);
        wait_drain(1'b0);

        // Push latency at beat 7 and a late push at beat 9.
        do_reset();
        a_w = {10'h0F0, 10'h3C3, 10'h001};
        b_w = {10'h1E5, 10'h21A, 10'h38E};
        q1.push_back(a_w);
        q1.push_back(FILL);
        q1.push_back(b_w);
        tick(7);
        in_data = a_w;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        at_neg();
        chk("t5_idle_out", 64'(ser_data), 64'd0);
        tick(2);
        at_neg();
        chk("t5_strobe", 64'(word_strobe), 64'd1);
        chk("t5_first_bits", 64'(ser_data), 64'b011);
        chk("t5_no_underrun", 64'(underrun), 64'd0);
        tick(9);
        in_data = b_w;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        at_neg();
        chk("t5_late_underrun", 64'(underrun), 64'd1);
        chk("t5_fill_bit0", 64'(ser_data), 64'd0);
        wait_drain(1'b0);

        // Reset mid-symbol with two words queued.
        do_reset();
        in_data = 30'h0ABCDEF1;
        in_valid = 1'b1;
        tick(1);
        in_data = 30'h1234567;
        tick(1);
        in_valid = 1'b0;
        tick(8);
        in_data = 30'h3FF00FF;
        in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(3);
        rst = 1'b1;
        at_neg();
        chk("t6_ready_in_rst", 64'(in_ready), 64'd0);
        tick(1);
        rst = 1'b0;
        q1.push_back(FILL);
        at_neg();
        chk("t6_ser_data0", 64'(ser_data), 64'd0);
        chk("t6_ser_clk0", 64'(ser_clk), 64'd0);
        chk("t6_strobe0", 64'(word_strobe), 64'd0);
        chk("t6_underrun0", 64'(underrun), 64'd0);
        tick(10);
        at_neg();
        chk("t6_strobe", 64'(word_strobe), 64'd1);
        chk("t6_underrun", 64'(underrun), 64'd1);
        wait_drain(1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
